au_nibble_sequencer: RTL

//  Multi-cycle controller for the 4-bit arithmetic slice (A + mux(B) + Cin).

---
 rtl/au_seq_pkg.sv | 57 +++++
 rtl/au_nibble_sequencer_au4_slice.sv | 23 ++
 rtl/au_nibble_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/au_seq_pkg.sv
// rtl/au_seq_pkg.sv - shared types, per-op slice controls and mux helper for the nibble sequencer
package au_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_INC = 2'b10,
    OP_DEC = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Slice select S per op
  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_INC = 2'b10;
  localparam logic [1:0] SEL_DEC = 2'b11;

  // Initial carry-in per op
  localparam logic CIN_ADD = 1'b0;
  localparam logic CIN_SUB = 1'b1;
  localparam logic CIN_INC = 1'b1;
  localparam logic CIN_DEC = 1'b0;

  function automatic logic [1:0] op_sel(input op_t op);
    case (op)
      OP_ADD:  return SEL_ADD;
      OP_SUB:  return SEL_SUB;
      OP_INC:  return SEL_INC;
      default: return SEL_DEC;
    endcase
  endfunction

  function automatic logic op_cin(input op_t op);
    case (op)
      OP_ADD:  return CIN_ADD;
      OP_SUB:  return CIN_SUB;
      OP_INC:  return CIN_INC;
      default: return CIN_DEC;
    endcase
  endfunction

  // Second adder operand: B, ~B, 0 (INC adds only Cin), all-ones (DEC adds -1)
  function automatic logic [3:0] slice_mux(input logic [1:0] sel, input logic [3:0] b);
    case (sel)
      2'b00:   return b;
      2'b01:   return ~b;
      2'b10:   return 4'h0;
      default: return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/au_nibble_sequencer_au4_slice.sv
// rtl/au_nibble_sequencer_au4_slice.sv - 4-bit operand mux plus ripple adder slice
module au4_slice
  import au_seq_pkg::*;
(
  input  logic [1:0] sel,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] d,
  output logic       cout
);

  logic [4:0] sum;

  // A + mux(B) + Cin, carry taken from bit 4
  always_comb begin
    sum = {1'b0, a} + {1'b0, slice_mux(sel, b)} + {4'b0000, cin};
  end

  assign d    = sum[3:0];
  assign cout = sum[4];

endmodule

// File: rtl/au_nibble_sequencer.sv
// rtl/au_nibble_sequencer.sv - nibble-serial ADD/SUB/INC/DEC controller; AU_SEQ_FLAGS_EN adds zero/ovf outputs
module au_nibble_sequencer
  import au_seq_pkg::*;
#(
  parameter int NIBBLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
`ifdef AU_SEQ_FLAGS_EN
  output logic                 zero,
  output logic                 ovf,
`endif
  output logic                 busy
);

  localparam int W = 4 * NIBBLES;
  localparam logic [2:0] LAST = 3'(NIBBLES - 1);

  state_t       state;
  op_t          op_q;
  logic [W-1:0] a_sh;
  logic [W-1:0] b_sh;
  logic [W-1:0] r_sh;
  logic [W-1:0] r_next;
  logic [2:0]   cnt;
  logic         carry;
  logic [1:0]   sel;
  logic [3:0]   d;
  logic         c_out;

  assign sel = op_sel(op_q);

  au4_slice u_slice (
    .sel  (sel),
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry),
    .d    (d),
    .cout (c_out)
  );

  // New sum nibble enters at the top; after NIBBLES shifts the LSB nibble sits at bit 0
  always_comb begin
    r_next = (r_sh >> 4) | (W'(d) << (W - 4));
  end

`ifdef AU_SEQ_FLAGS_EN
  logic [3:0] y;
  always_comb begin
    y = slice_mux(sel, b_sh[3:0]);
  end
`endif

  // Sequencer FSM with operand/result shift registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_ADD;
      a_sh      <= '0;
      b_sh      <= '0;
      r_sh      <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
`ifdef AU_SEQ_FLAGS_EN
      zero      <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            op_q     <= op_t'(op);
            a_sh     <= a;
            b_sh     <= b;
            cnt      <= '0;
            carry    <= op_cin(op_t'(op));
            state    <= ST_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          r_sh  <= r_next;
          carry <= c_out;
          cnt   <= cnt + 3'd1;
          if (cnt == LAST) begin
            state     <= ST_DONE;
            result    <= r_next;
            cout      <= c_out;
            out_valid <= 1'b1;
`ifdef AU_SEQ_FLAGS_EN
            zero      <= (r_next == '0);
            ovf       <= (a_sh[3] == y[3]) && (d[3] != a_sh[3]);
`endif
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
